// File: rtl/sobel_hls_deadlock_param_monitor_if.sv
// Monitor-side signal bundle for the sobel HLS deadlock monitor: stall/idle inputs,
// channel mask, clear and the registered debug outputs.
interface sobel_hls_deadlock_param_monitor_if #(
  parameter int unsigned NUM_AXIS = 3,
  parameter int unsigned NUM_INST = 3,
  parameter int unsigned NUM_BLK  = 1,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
);
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_BLK-1:0]  inst_block_sigs;
  logic [NUM_AXIS-1:0] axis_mask;
  logic                clear;
  logic                block;
  logic [IDX_W-1:0]    block_chan;
  logic                block_by_inst;
  logic [CNT_W-1:0]    block_cycles;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, axis_mask, clear,
    input  block, block_chan, block_by_inst, block_cycles
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, axis_mask, clear,
    output block, block_chan, block_by_inst, block_cycles
  );
endinterface

// File: rtl/sobel_hls_deadlock_param_monitor.sv
// Deadlock monitor for one sobel HLS dataflow region: flags a qualified stall that persists
// THRESH cycles. Define DEADLOCK_MON_STICKY_EN to latch BLOCKED until clear or reset.
module sobel_hls_deadlock_param_monitor #(
  parameter int unsigned NUM_AXIS = 3,
  parameter int unsigned NUM_INST = 3,
  parameter int unsigned NUM_BLK  = 1,
  parameter int unsigned THRESH   = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input logic                               clock,
  input logic                               reset,
  sobel_hls_deadlock_param_monitor_if.slave mon
);
  typedef enum logic [1:0] {StIdle, StSuspect, StBlocked} state_e;

  localparam logic [CNT_W-1:0] ThreshC = CNT_W'(THRESH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [IDX_W-1:0]    chan_q, chan_d;
  logic                by_inst_q, by_inst_d;
  logic [NUM_AXIS-1:0] masked;
  logic [IDX_W-1:0]    first_idx;
  logic                raw;
  logic                enter;

  assign masked = mon.axis_block_sigs & mon.axis_mask;
  // An all-idle region is finished, not deadlocked.
  assign raw = ((|masked) | (|mon.inst_block_sigs)) & ~(&mon.inst_idle_sigs);

  always_comb begin
    first_idx = '0;
    for (int i = int'(NUM_AXIS) - 1; i >= 0; i--) begin
      if (masked[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    cyc_d     = cyc_q;
    chan_d    = chan_q;
    by_inst_d = by_inst_q;
    enter     = 1'b0;

    if (!raw) begin
      pcnt_d = '0;
    end else if (pcnt_q < ThreshC) begin
      pcnt_d = pcnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (raw) begin
          if (THRESH == 1) enter = 1'b1;
          else             state_d = StSuspect;
        end
      end
      StSuspect: begin
        if (!raw)                          state_d = StIdle;
        else if (pcnt_q == ThreshC - 1'b1) enter = 1'b1;
      end
      StBlocked: begin
        if (raw && !(&cyc_q)) cyc_d = cyc_q + 1'b1;
`ifdef DEADLOCK_MON_STICKY_EN
        state_d = StBlocked;
`else
        if (!raw) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (enter) begin
      state_d   = StBlocked;
      chan_d    = first_idx;
      by_inst_d = ~(|masked);
      cyc_d     = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || mon.clear) begin
      state_q   <= StIdle;
      pcnt_q    <= '0;
      cyc_q     <= '0;
      chan_q    <= '0;
      by_inst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      cyc_q     <= cyc_d;
      chan_q    <= chan_d;
      by_inst_q <= by_inst_d;
    end
  end

  assign mon.block         = (state_q == StBlocked);
  assign mon.block_chan    = chan_q;
  assign mon.block_by_inst = by_inst_q;
  assign mon.block_cycles  = cyc_q;
endmodule
